hold_pulse_tx: RTL

- Transmit end of the car's level-qualified signalling line.
- Converts a requested count `code` into exactly `code` high pulses on `tx_line`.
- Each pulse is held long enough to pass the downstream 50-cycle hold qualifier. Pulses are separated by low gaps so the qualifier's counter clears between them.
- Sits between the control FSM (which issues `req`/`code`) and the physical or looped-back qualified input.

---
 rtl/hold_pulse_tx.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/hold_pulse_tx.sv
// Purpose : turns a requested count into that many long high pulses on a level-qualified line.
// Latency : first pulse edge 1 cycle after accept; done 1 cycle after the final HOLD (or TAIL).
// Backpr. : one frame at a time; req is taken only while ready=1, otherwise ignored (not queued).
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   start         - global enable; low aborts to IDLE on the next edge without done
//   req, code     - frame request and pulse count, captured when req && ready
//   ready         - combinational, IDLE and enabled
//   busy          - registered, high while pulses/gaps are being emitted
//   tx_line       - registered line output
//   done          - registered, one-cycle completion strobe
// Optional macro HOLD_PULSE_TX_GUARD_EN adds a low TAIL of GAP_CYCLES after the final pulse.
module hold_pulse_tx #(
  parameter int HOLD_CYCLES = 60,
  parameter int GAP_CYCLES  = 60,
  parameter int CNT_W       = 11,
  parameter int CODE_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              req,
  input  logic [CODE_W-1:0] code,
  output logic              ready,
  output logic              busy,
  output logic              tx_line,
  output logic              done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HOLD = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
`ifdef HOLD_PULSE_TX_GUARD_EN
  localparam logic [2:0] S_TAIL = 3'd3;
`endif
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CODE_W-1:0] REM_ONE   = CODE_W'(1);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] rem_q, rem_d;
  logic              tx_line_q, busy_q, done_q;
  logic              tx_line_d, busy_d, done_d;

  assign ready   = (state_q == S_IDLE) && start;
  assign busy    = busy_q;
  assign tx_line = tx_line_q;
  assign done    = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    if (!start) begin
      // Abort: drop straight to IDLE, no done strobe.
      state_d = S_IDLE;
      cnt_d   = '0;
      rem_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (req && ready) begin
            if (code != '0) begin
              rem_d   = code;
              state_d = S_HOLD;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d = '0;
            if (rem_q == REM_ONE) begin
              rem_d = '0;
`ifdef HOLD_PULSE_TX_GUARD_EN
              state_d = S_TAIL;
`else
              state_d = S_DONE;
`endif
            end else begin
              rem_d   = rem_q - REM_ONE;
              state_d = S_GAP;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
`ifdef HOLD_PULSE_TX_GUARD_EN
        S_TAIL: begin
          // Trailing low so the receiver's qualifier clears before the next frame.
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
`endif
        S_DONE: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
        default: begin
          cnt_d   = '0;
          rem_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    tx_line_d = (state_d == S_HOLD);
    done_d    = (state_d == S_DONE);
    busy_d    = (state_d == S_HOLD) || (state_d == S_GAP);
`ifdef HOLD_PULSE_TX_GUARD_EN
    busy_d    = busy_d || (state_d == S_TAIL);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      tx_line_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      tx_line_q <= tx_line_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule
